// File: rtl/regfile_writeback_unit.sv
// Architectural register file and predicate-status bit, written from the writeback
// bundle, with zero-latency bypassed reads and a retired-bundle counter.
module regfile_writeback_unit #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter bit ZERO_REG = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              wb_valid,
    input  logic              wb_use_rw,
    input  logic [ADDR_W-1:0] wb_rw_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_write_ps,
    input  logic              wb_ps,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              ps,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              ps_q;
    logic              wr_en;
    logic              ps_en;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = (32'(a) < NUM_REGS);
        is_zero  = ZERO_REG && (a == '0);
        return in_range && !is_zero;
    endfunction

    assign wr_en = wb_valid && wb_use_rw && addr_ok(wb_rw_addr);
    assign ps_en = wb_valid && wb_write_ps;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            ps_q       <= 1'b0;
            retire_cnt <= '0;
        end else begin
            if (wr_en) begin
                regs[wb_rw_addr] <= wb_data;
            end
            if (ps_en) begin
                ps_q <= wb_ps;
            end
            if (wb_valid) begin
                retire_cnt <= retire_cnt + 1'b1;
            end
        end
    end

    // R0 (when hardwired) and out-of-range addresses read 0 even under bypass.
    function automatic logic [DATA_W-1:0] port_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] val;
        val = '0;
        if (n_rst && addr_ok(a)) begin
            if (wr_en && (wb_rw_addr == a)) begin
                val = wb_data;
            end else begin
                val = regs[a];
            end
        end
        return val;
    endfunction

    always_comb begin
        ra_data = port_read(ra_addr);
        rt_data = port_read(rt_addr);
        ps      = 1'b0;
        if (n_rst) begin
            ps = ps_en ? wb_ps : ps_q;
        end
    end

endmodule
